uart_rx_pkt_ctrl: RTL and testbench
===================================

// Module: uart_rx_pkt_ctrl
// PURPOSE
//  Sequences the UART receiver's byte output into framed packets: SYNC, LEN, LEN payload bytes, CHK.
//  Buffers the payload and checks it; releases it downstream on a valid/ready stream only after CHK passes.
//  Sits between the UART receiver (ready/data) and the command decoder.
// PARAMETERS
//  SYNC_BYTE     8'hA5   frame start marker
//  MAX_LEN       16      max payload bytes (1..255); buffer depth
//  TIMEOUT_CLKS  20000   inter-byte timeout in clk cycles (only with UART_PKT_TIMEOUT_EN)
// PORTS
//  clk        in   1  system clock, all logic on posedge
//  rst        in   1  synchronous active-high reset
//  rx_ready   in   1  receiver byte-valid level (held high until next start bit)
//  rx_data    in   8  receiver byte, stable while rx_ready high
//  out_valid  out  1  payload byte available
//  out_data   out  8  payload byte
//  out_last   out  1  high with final payload byte
//  out_ready  in   1  downstream accepts byte when out_valid&out_ready
//  pkt_ok     out  1  one-cycle pulse: CHK matched, drain begins next cycle
//  pkt_err    out  1  one-cycle pulse on any frame error
//  err_code   out  3  valid with pkt_err: 1=bad LEN, 2=bad CHK, 3=timeout, 4=overrun
// BEHAVIOUR
//  - Byte strobe = rising edge of rx_ready (registered previous value); one strobe per received byte.
//  - Reset: state=HUNT; out_valid, out_last, pkt_ok, pkt_err=0; err_code=0; buffer, counters, chk cleared.
//  - FSM:
//    - HUNT: strobe with SYNC_BYTE -> LEN; other bytes ignored silently.
//    - LEN: strobe: byte 0 or >MAX_LEN -> pkt_err code 1, HUNT.
//      Else len=byte, chk=byte, idx=0 -> PAYLOAD.
//    - PAYLOAD: strobe: buf[idx]<=byte, chk^=byte, idx++; idx reaching len -> CHK.
//    - CHK: strobe: byte==chk -> pkt_ok, DRAIN, rd_idx=0. Else pkt_err code 2, HUNT.
//    - DRAIN: out_valid=1, out_data=buf[rd_idx], out_last=(rd_idx==len-1).
//      Each handshake rd_idx++; handshake on last byte -> HUNT, out_valid=0 next cycle.
//  - CHK = XOR of LEN byte and all payload bytes; SYNC excluded.
//  - Latency: pkt_ok asserts the cycle after the CHK strobe; out_valid asserts the cycle after pkt_ok.
//  - out_data/out_last held stable while out_valid & !out_ready; no combinational out_ready->out_valid path.
//  - Overrun: strobe during DRAIN -> pkt_err code 4; byte dropped; drain continues.
//    That byte is not parsed as SYNC.
//  - pkt_ok and pkt_err never assert in the same cycle.
//  - A single error is reported per cycle.
//  - Reset mid-operation, including mid-DRAIN, discards the packet; out_valid drops the cycle after rst.
//  - idx/rd_idx width = clog2(MAX_LEN+1). len never exceeds MAX_LEN, so no wrap.
// CONFIGURATION
//  UART_PKT_TIMEOUT_EN defined:
//   - Counter runs in LEN/PAYLOAD/CHK; cleared on every strobe and on entry to LEN.
//   - Reaching TIMEOUT_CLKS -> pkt_err code 3, HUNT.
//   - Strobe and expiry in the same cycle: the strobe wins, no error.
//  Undefined: no counter logic; a partial frame waits indefinitely; code 3 is never produced.
// TESTING
//  - rst, then A5 03 11 22 33 03 (03^11^22^33=03), out_ready=1
//    -> pkt_ok once; 11,22,33 on consecutive cycles; out_last with 33.
//  - Same frame, out_ready low 5 cycles after pkt_ok -> out_valid=1, out_data=11 held; then drains in order.
//  - 00 FF A5 00 -> pkt_err code 1, no out_valid.
//    Then A5 01 7E 7F -> pkt_ok; out 7E with out_last.
//  - A5 02 10 20 31 -> pkt_err code 2 (expected 32); no out_valid; state HUNT.
//  - Frame A5 02 10 20 32, out_ready=0, then byte 55 arrives -> pkt_err code 4; drain yields 10,20 only.
//  - TIMEOUT_EN, TIMEOUT_CLKS=100: A5 02 10, then idle 100 clks -> pkt_err code 3.
//    Next A5 01 AA AB -> pkt_ok.
//    Repeat without the macro -> no error, FSM waits.
//  - rst pulse during PAYLOAD of A5 03 11 -> all outputs 0 next cycle.
//    Then a fresh frame parses correctly.

Source files
------------

// File: rtl/uart_rx_pkt_ctrl_if.sv
// UART packet controller bus: receiver byte input, payload stream output, frame status pulses.
// master drives the receiver side and out_ready; slave is the packet controller.
interface uart_rx_pkt_ctrl_if;
  logic       rx_ready;
  logic [7:0] rx_data;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_last;
  logic       out_ready;
  logic       pkt_ok;
  logic       pkt_err;
  logic [2:0] err_code;

  modport master (
    output rx_ready, rx_data, out_ready,
    input  out_valid, out_data, out_last, pkt_ok, pkt_err, err_code
  );

  modport slave (
    input  rx_ready, rx_data, out_ready,
    output out_valid, out_data, out_last, pkt_ok, pkt_err, err_code
  );
endinterface

// File: rtl/uart_rx_pkt_ctrl.sv
// Frames UART bytes as SYNC,LEN,payload,CHK; buffers payload and streams it out only after CHK matches.
// Latency: pkt_ok one cycle after the CHK strobe, out_valid one cycle after pkt_ok.
// Backpressure: out_valid/ready stream holds data while stalled; UART_PKT_TIMEOUT_EN adds an inter-byte timeout.
module uart_rx_pkt_ctrl #(
  parameter logic [7:0] SYNC_BYTE = 8'hA5,
  parameter int         MAX_LEN   = 16
`ifdef UART_PKT_TIMEOUT_EN
  , parameter int       TIMEOUT_CLKS = 20000
`endif
) (
  input logic               clk,
  input logic               rst,
  uart_rx_pkt_ctrl_if.slave bus
);

  localparam int IW = $clog2(MAX_LEN + 1);
  localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  localparam logic [2:0] ERR_LEN     = 3'd1;
  localparam logic [2:0] ERR_CHK     = 3'd2;
  localparam logic [2:0] ERR_TIMEOUT = 3'd3;
  localparam logic [2:0] ERR_OVERRUN = 3'd4;

  typedef enum logic [2:0] {
    ST_HUNT,
    ST_LEN,
    ST_PAYLOAD,
    ST_CHK,
    ST_DRAIN
  } state_t;

  state_t          state_q,     state_d;
  logic            rx_prev_q,   rx_prev_d;
  logic [IW-1:0]   len_q,       len_d;
  logic [IW-1:0]   idx_q,       idx_d;
  logic [IW-1:0]   rd_idx_q,    rd_idx_d;
  logic [7:0]      chk_q,       chk_d;
  logic [7:0]      buf_q [MAX_LEN];
  logic [7:0]      buf_d [MAX_LEN];
  logic            out_valid_q, out_valid_d;
  logic [7:0]      out_data_q,  out_data_d;
  logic            out_last_q,  out_last_d;
  logic            pkt_ok_q,    pkt_ok_d;
  logic            pkt_err_q,   pkt_err_d;
  logic [2:0]      err_code_q,  err_code_d;

`ifdef UART_PKT_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CLKS + 1);
  logic [TW-1:0]   tmo_q, tmo_d;
  logic            tmo_exp;
`endif

  logic            strobe;
  logic            hs;
  logic [IW-1:0]   idx_nxt;
  logic [IW-1:0]   rd_nxt;

  assign strobe  = bus.rx_ready & ~rx_prev_q;
  assign hs      = out_valid_q & bus.out_ready;
  assign idx_nxt = idx_q + 1'b1;
  assign rd_nxt  = rd_idx_q + 1'b1;

  always_comb begin
    state_d     = state_q;
    rx_prev_d   = bus.rx_ready;
    len_d       = len_q;
    idx_d       = idx_q;
    rd_idx_d    = rd_idx_q;
    chk_d       = chk_q;
    buf_d       = buf_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    pkt_ok_d    = 1'b0;
    pkt_err_d   = 1'b0;
    err_code_d  = 3'd0;

`ifdef UART_PKT_TIMEOUT_EN
    // Counter is zero outside the frame body and after each strobe, so entry to LEN starts from zero.
    tmo_d   = '0;
    tmo_exp = 1'b0;
    if ((state_q inside {ST_LEN, ST_PAYLOAD, ST_CHK}) && !strobe) begin
      tmo_d   = tmo_q + 1'b1;
      tmo_exp = (tmo_d == TW'(TIMEOUT_CLKS));
    end
`endif

    case (state_q)
      ST_HUNT: begin
        if (strobe && (bus.rx_data == SYNC_BYTE)) begin
          state_d = ST_LEN;
        end
      end

      ST_LEN: begin
        if (strobe) begin
          if ((bus.rx_data == 8'd0) || (bus.rx_data > 8'(MAX_LEN))) begin
            pkt_err_d  = 1'b1;
            err_code_d = ERR_LEN;
            state_d    = ST_HUNT;
          end else begin
            len_d   = IW'(bus.rx_data);
            chk_d   = bus.rx_data;
            idx_d   = '0;
            state_d = ST_PAYLOAD;
          end
        end
      end

      ST_PAYLOAD: begin
        if (strobe) begin
          buf_d[idx_q[AW-1:0]] = bus.rx_data;
          chk_d                = chk_q ^ bus.rx_data;
          idx_d                = idx_nxt;
          if (idx_nxt == len_q) begin
            state_d = ST_CHK;
          end
        end
      end

      ST_CHK: begin
        if (strobe) begin
          if (bus.rx_data == chk_q) begin
            pkt_ok_d = 1'b1;
            rd_idx_d = '0;
            state_d  = ST_DRAIN;
          end else begin
            pkt_err_d  = 1'b1;
            err_code_d = ERR_CHK;
            state_d    = ST_HUNT;
          end
        end
      end

      ST_DRAIN: begin
        // A byte arriving mid-drain is dropped, never reparsed as SYNC.
        if (strobe) begin
          pkt_err_d  = 1'b1;
          err_code_d = ERR_OVERRUN;
        end
        if (!out_valid_q) begin
          out_valid_d = 1'b1;
          out_data_d  = buf_q[0];
          out_last_d  = (len_q == IW'(1));
        end else if (hs) begin
          if (out_last_q) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            state_d     = ST_HUNT;
          end else begin
            rd_idx_d   = rd_nxt;
            out_data_d = buf_q[rd_nxt[AW-1:0]];
            out_last_d = (rd_nxt == (len_q - 1'b1));
          end
        end
      end

      default: begin
        state_d = ST_HUNT;
      end
    endcase

`ifdef UART_PKT_TIMEOUT_EN
    if (tmo_exp) begin
      pkt_err_d  = 1'b1;
      err_code_d = ERR_TIMEOUT;
      state_d    = ST_HUNT;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_HUNT;
      rx_prev_q   <= 1'b0;
      len_q       <= '0;
      idx_q       <= '0;
      rd_idx_q    <= '0;
      chk_q       <= 8'd0;
      for (int i = 0; i < MAX_LEN; i++) begin
        buf_q[i] <= 8'd0;
      end
      out_valid_q <= 1'b0;
      out_data_q  <= 8'd0;
      out_last_q  <= 1'b0;
      pkt_ok_q    <= 1'b0;
      pkt_err_q   <= 1'b0;
      err_code_q  <= 3'd0;
`ifdef UART_PKT_TIMEOUT_EN
      tmo_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      rx_prev_q   <= rx_prev_d;
      len_q       <= len_d;
      idx_q       <= idx_d;
      rd_idx_q    <= rd_idx_d;
      chk_q       <= chk_d;
      buf_q       <= buf_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      pkt_ok_q    <= pkt_ok_d;
      pkt_err_q   <= pkt_err_d;
      err_code_q  <= err_code_d;
`ifdef UART_PKT_TIMEOUT_EN
      tmo_q       <= tmo_d;
`endif
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_last  = out_last_q;
  assign bus.pkt_ok    = pkt_ok_q;
  assign bus.pkt_err   = pkt_err_q;
  assign bus.err_code  = err_code_q;

endmodule

// File: tb/tb_uart_rx_pkt_ctrl.sv
// Bench for uart_rx_pkt_ctrl: directed frame table, multi-cycle corner sequences, random frames vs a parse model.
module tb_uart_rx_pkt_ctrl;
  localparam int         MAXL = 16;
  localparam logic [7:0] SYNC = 8'hA5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_rx_pkt_ctrl_if bus();

  uart_rx_pkt_ctrl #(
    .SYNC_BYTE(SYNC),
    .MAX_LEN(MAXL)
`ifdef UART_PKT_TIMEOUT_EN
    , .TIMEOUT_CLKS(100)
`endif
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Event log filled by the monitor, read by the main sequence through start indices.
  int         ok_q[$];
  int         vrise_q[$];
  logic [2:0] err_q[$];
  logic [7:0] out_q[$];
  logic       last_q[$];
  int         cyc = 0;
  int         stab_viol = 0;
  int         both_cnt = 0;
  logic       prev_stall = 1'b0;
  logic       prev_valid = 1'b0;
  logic [7:0] prev_data = 8'd0;
  logic       prev_last = 1'b0;

  always @(negedge clk) begin
    if (bus.pkt_ok) ok_q.push_back(cyc);
    if (bus.pkt_err) err_q.push_back(bus.err_code);
    if (bus.pkt_ok && bus.pkt_err) both_cnt++;
    if (bus.out_valid && !prev_valid) vrise_q.push_back(cyc);
    if (bus.out_valid && bus.out_ready) begin
      out_q.push_back(bus.out_data);
      last_q.push_back(bus.out_last);
    end
    if (prev_stall && !rst &&
        !(bus.out_valid && bus.out_data == prev_data && bus.out_last == prev_last))
      stab_viol++;
    prev_stall = bus.out_valid && !bus.out_ready && !rst;
    prev_valid = bus.out_valid;
    prev_data  = bus.out_data;
    prev_last  = bus.out_last;
    cyc++;
  end

  bit   rdy_mode  = 1'b0;
  logic rdy_fixed = 1'b1;

  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bus.out_ready = rdy_mode ? 1'($urandom) : rdy_fixed;
    end
  end

  typedef struct {
    int           n_in;
    logic [159:0] in_b;
    int           n_ok;
    logic [2:0]   err;
    int           n_out;
    logic [127:0] out_b;
  } vec_t;

  vec_t       vt[8];
  logic [7:0] stim[$];
  int         exp_ok;
  logic [2:0] exp_err[$];
  logic [7:0] exp_out[$];
  int         s_o, s_e, s_d, s_v;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.rx_data  = b;
    bus.rx_ready = 1'b1;
    repeat (3) tick();
    bus.rx_ready = 1'b0;
    repeat (2) tick();
  endtask

  task automatic send_stim();
    foreach (stim[i]) send_byte(stim[i]);
  endtask

  task automatic wait_idle();
    int n = 0;
    repeat (2) tick();
    while (bus.out_valid && n < 500) begin
      tick();
      n++;
    end
    check("drain_bound", bus.out_valid, 1'b0);
  endtask

  task automatic snap();
    s_o = ok_q.size();
    s_e = err_q.size();
    s_d = out_q.size();
    s_v = vrise_q.size();
  endtask

  task automatic set_exp(input int ok, input logic [2:0] err, input int nout, input logic [127:0] ob);
    exp_ok = ok;
    exp_err.delete();
    exp_out.delete();
    if (err != 3'd0) exp_err.push_back(err);
    for (int k = 0; k < nout; k++) exp_out.push_back(ob[8*(nout-1-k) +: 8]);
  endtask

  task automatic compare(input string name);
    int ne, nd;
    check({name, " ok_cnt"}, ok_q.size() - s_o, exp_ok);
    ne = err_q.size() - s_e;
    check({name, " err_cnt"}, ne, exp_err.size());
    for (int k = 0; k < ne && k < exp_err.size(); k++)
      check($sformatf("%s err_code[%0d]", name, k), err_q[s_e+k], exp_err[k]);
    nd = out_q.size() - s_d;
    check({name, " out_cnt"}, nd, exp_out.size());
    for (int k = 0; k < nd && k < exp_out.size(); k++) begin
      check($sformatf("%s out_data[%0d]", name, k), out_q[s_d+k], exp_out[k]);
      check($sformatf("%s out_last[%0d]", name, k), last_q[s_d+k], k == exp_out.size() - 1);
    end
    if (exp_ok > 0 && ok_q.size() > s_o && vrise_q.size() > s_v)
      check({name, " valid_latency"}, vrise_q[s_v] - ok_q[s_o], 1);
    check({name, " hold_stable"}, stab_viol, 0);
    check({name, " ok_err_excl"}, both_cnt, 0);
  endtask

  // Reference: scan a byte list for frames using the framing rules directly.
  task automatic model_run();
    int i = 0;
    int L;
    logic [7:0] c;
    exp_ok = 0;
    exp_err.delete();
    exp_out.delete();
    while (i < stim.size()) begin
      if (stim[i] != SYNC) begin
        i++;
        continue;
      end
      if (i + 1 >= stim.size()) break;
      L = int'(stim[i+1]);
      if (L == 0 || L > MAXL) begin
        exp_err.push_back(3'd1);
        i += 2;
        continue;
      end
      if (i + 2 + L >= stim.size()) break;
      c = stim[i+1];
      for (int k = 0; k < L; k++) c ^= stim[i+2+k];
      if (c == stim[i+2+L]) begin
        exp_ok++;
        for (int k = 0; k < L; k++) exp_out.push_back(stim[i+2+k]);
      end else begin
        exp_err.push_back(3'd2);
      end
      i += 3 + L;
    end
  endtask

  task automatic push_frame(input bit good);
    int L;
    logic [7:0] c, b;
    L = $urandom_range(1, MAXL);
    c = 8'(L);
    stim.push_back(SYNC);
    stim.push_back(8'(L));
    for (int k = 0; k < L; k++) begin
      b = 8'($urandom);
      c ^= b;
      stim.push_back(b);
    end
    stim.push_back(good ? c : c ^ 8'($urandom_range(1, 255)));
  endtask

  task automatic run_vec(input int t);
    stim.delete();
    for (int i = 0; i < vt[t].n_in; i++) stim.push_back(vt[t].in_b[8*(vt[t].n_in-1-i) +: 8]);
    set_exp(vt[t].n_ok, vt[t].err, vt[t].n_out, vt[t].out_b);
    snap();
    send_stim();
    wait_idle();
    compare($sformatf("vec%0d", t));
  endtask

  initial begin
    int n;
    vt[0] = '{6,  160'hA5_03_11_22_33_03, 1, 3'd0, 3, 128'h11_22_33};
    vt[1] = '{4,  160'h00_FF_A5_00,       0, 3'd1, 0, 128'h0};
    vt[2] = '{4,  160'hA5_01_7E_7F,       1, 3'd0, 1, 128'h7E};
    vt[3] = '{5,  160'hA5_02_10_20_31,    0, 3'd2, 0, 128'h0};
    vt[4] = '{2,  160'hA5_11,             0, 3'd1, 0, 128'h0};
    vt[5] = '{19, 160'hA5_10_01_02_03_04_05_06_07_08_09_0A_0B_0C_0D_0E_0F_10_00, 1, 3'd0, 16,
              128'h01_02_03_04_05_06_07_08_09_0A_0B_0C_0D_0E_0F_10};
    vt[6] = '{5,  160'h5A_A5_01_00_01,    1, 3'd0, 1, 128'h00};
    vt[7] = '{4,  160'hA5_01_A5_A4,       1, 3'd0, 1, 128'hA5};

    bus.rx_ready = 1'b0;
    bus.rx_data  = 8'd0;
    rst = 1'b1;
    repeat (3) tick();
    check("rst out_valid", bus.out_valid, 1'b0);
    check("rst out_last",  bus.out_last,  1'b0);
    check("rst pkt_ok",    bus.pkt_ok,    1'b0);
    check("rst pkt_err",   bus.pkt_err,   1'b0);
    check("rst err_code",  bus.err_code,  3'd0);
    rst = 1'b0;
    repeat (2) tick();

    for (int t = 0; t < 8; t++) run_vec(t);

    // Backpressure: hold out_ready low well past pkt_ok.
    rdy_fixed = 1'b0;
    tick();
    snap();
    stim.delete();
    for (int i = 0; i < vt[0].n_in; i++) stim.push_back(vt[0].in_b[8*(vt[0].n_in-1-i) +: 8]);
    send_stim();
    check("bp ok_seen", ok_q.size() - s_o, 1);
    n = 0;
    while (ok_q.size() > s_o && cyc < ok_q[s_o] + 6 && n < 20) begin
      tick();
      n++;
    end
    check("bp held_valid", bus.out_valid, 1'b1);
    check("bp held_data",  bus.out_data,  8'h11);
    check("bp held_last",  bus.out_last,  1'b0);
    rdy_fixed = 1'b1;
    wait_idle();
    set_exp(1, 3'd0, 3, 128'h11_22_33);
    compare("backpressure");

    // Overrun: byte during drain is reported and dropped.
    rdy_fixed = 1'b0;
    tick();
    snap();
    stim = '{8'hA5, 8'h02, 8'h10, 8'h20, 8'h32, 8'h55};
    send_stim();
    rdy_fixed = 1'b1;
    wait_idle();
    set_exp(1, 3'd4, 2, 128'h10_20);
    compare("overrun");

    // Overrun with the SYNC value must not start a new frame.
    rdy_fixed = 1'b0;
    tick();
    snap();
    stim = '{8'hA5, 8'h02, 8'h10, 8'h20, 8'h32, 8'hA5};
    send_stim();
    rdy_fixed = 1'b1;
    wait_idle();
    stim = '{8'h01, 8'h7E, 8'h7F};
    send_stim();
    wait_idle();
    set_exp(1, 3'd4, 2, 128'h10_20);
    compare("overrun_sync");

    // Idle gap inside a frame.
    snap();
    stim = '{8'hA5, 8'h02, 8'h10};
    send_stim();
    repeat (150) tick();
`ifdef UART_PKT_TIMEOUT_EN
    stim = '{8'hA5, 8'h01, 8'hAA, 8'hAB};
    send_stim();
    wait_idle();
    set_exp(1, 3'd3, 1, 128'hAA);
`else
    check("idle no_err", err_q.size() - s_e, 0);
    stim = '{8'h20, 8'h32};
    send_stim();
    wait_idle();
    set_exp(1, 3'd0, 2, 128'h10_20);
`endif
    compare("idle_gap");

    // Reset during PAYLOAD.
    stim = '{8'hA5, 8'h03, 8'h11};
    send_stim();
    rst = 1'b1;
    tick();
    check("rstp out_valid", bus.out_valid, 1'b0);
    check("rstp pkt_ok",    bus.pkt_ok,    1'b0);
    check("rstp pkt_err",   bus.pkt_err,   1'b0);
    check("rstp err_code",  bus.err_code,  3'd0);
    rst = 1'b0;
    tick();
    run_vec(2);

    // Reset during DRAIN discards the rest of the packet.
    rdy_fixed = 1'b0;
    tick();
    stim.delete();
    for (int i = 0; i < vt[0].n_in; i++) stim.push_back(vt[0].in_b[8*(vt[0].n_in-1-i) +: 8]);
    send_stim();
    n = 0;
    while (!bus.out_valid && n < 50) begin
      tick();
      n++;
    end
    check("rstd valid_before", bus.out_valid, 1'b1);
    snap();
    rst = 1'b1;
    tick();
    check("rstd out_valid", bus.out_valid, 1'b0);
    check("rstd out_last",  bus.out_last,  1'b0);
    rst = 1'b0;
    rdy_fixed = 1'b1;
    repeat (5) tick();
    check("rstd no_out", out_q.size() - s_d, 0);
    run_vec(0);

    // Random chunks: garbage, bad frames, then one final frame, random out_ready.
    rdy_mode = 1'b1;
    for (int it = 0; it < 40; it++) begin
      logic [7:0] g;
      int nbad;
      stim.delete();
      repeat ($urandom_range(0, 3)) begin
        g = 8'($urandom);
        stim.push_back(g == SYNC ? 8'h5A : g);
      end
      nbad = $urandom_range(0, 2);
      for (int k = 0; k < nbad; k++) begin
        if ($urandom_range(0, 1) == 0) begin
          stim.push_back(SYNC);
          stim.push_back(($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(MAXL + 1, 255)));
        end else begin
          push_frame(1'b0);
        end
      end
      push_frame($urandom_range(0, 9) < 7);
      model_run();
      snap();
      send_stim();
      wait_idle();
      compare($sformatf("rand%0d", it));
    end
    rdy_mode = 1'b0;
    repeat (3) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
